// File: rtl/btb_pkg.sv
// Shared types and PLRU helpers for the 4-way branch target buffer.
package btb_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned TAG_W = 32 - IDX_W - 2;
  localparam int unsigned SETS  = 1 << IDX_W;
  localparam int unsigned WAYS  = 4;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

  // plru[2] root (0 -> ways 2/3), plru[1] picks in 0/1, plru[0] picks in 2/3 (0 -> way3)
  function automatic logic [1:0] plru_victim(input logic [2:0] plru);
    if (!plru[2]) return plru[0] ? 2'd2 : 2'd3;
    else          return plru[1] ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [2:0] plru_update(input logic [2:0] plru, input logic [1:0] way);
    logic [2:0] nxt;
    nxt = plru;
    unique case (way)
      2'd0: begin nxt[2] = 1'b0; nxt[1] = 1'b1; end
      2'd1: begin nxt[2] = 1'b0; nxt[1] = 1'b0; end
      2'd2: begin nxt[2] = 1'b1; nxt[0] = 1'b0; end
      default: begin nxt[2] = 1'b1; nxt[0] = 1'b1; end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btb_plru.sv
// Per-set tree pseudo-LRU state: victim lookup for the write set and update on write.
module btb_plru
  import btb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] set_i,
  input  logic             upd_en_i,
  input  logic [1:0]       upd_way_i,
  output logic [1:0]       victim_o
);

  logic [2:0] plru_q [SETS];

  assign victim_o = plru_victim(plru_q[set_i]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < int'(SETS); s++) plru_q[s] <= 3'b000;
    end else if (upd_en_i) begin
      plru_q[set_i] <= plru_update(plru_q[set_i], upd_way_i);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// 8-set, 4-way BTB with combinational lookup and clocked install/update.
// Optional same-cycle write-to-read forwarding under `define BTB_BYPASS_EN.
module branch_target_buffer
  import btb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] r_pc,
  output logic [31:0] target_out,
  output logic        btb_hit,
  input  logic [31:0] w_pc,
  input  logic        load,
  input  logic [31:0] target_in
);

  btb_entry_t mem_q [SETS][WAYS];

  logic [IDX_W-1:0] r_set, w_set;
  logic [TAG_W-1:0] r_tag, w_tag;
  logic             rd_hit;
  logic [31:0]      rd_target;
  logic             w_match;
  logic [1:0]       w_match_way;
  logic [1:0]       victim;
  logic [1:0]       wr_way;
  logic             unused_pc;

  assign r_set     = r_pc[IDX_W+1:2];
  assign r_tag     = r_pc[31:IDX_W+2];
  assign w_set     = w_pc[IDX_W+1:2];
  assign w_tag     = w_pc[31:IDX_W+2];
  assign unused_pc = ^{r_pc[1:0], w_pc[1:0]};

  always_comb begin
    rd_hit    = 1'b0;
    rd_target = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (mem_q[r_set][w].valid && mem_q[r_set][w].tag == r_tag) begin
        rd_hit    = 1'b1;
        rd_target = mem_q[r_set][w].target;
      end
    end
  end

  always_comb begin
    w_match     = 1'b0;
    w_match_way = 2'd0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (mem_q[w_set][w].valid && mem_q[w_set][w].tag == w_tag) begin
        w_match     = 1'b1;
        w_match_way = 2'(w);
      end
    end
  end

  // Existing entry is updated in place; otherwise the PLRU victim is replaced.
  assign wr_way = w_match ? w_match_way : victim;

  btb_plru u_plru (
    .clk_i     (clk),
    .rst_i     (rst),
    .set_i     (w_set),
    .upd_en_i  (load),
    .upd_way_i (wr_way),
    .victim_o  (victim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) mem_q[s][w] <= '0;
      end
    end else if (load) begin
      mem_q[w_set][wr_way] <= '{valid: 1'b1, tag: w_tag, target: target_in};
    end
  end

`ifdef BTB_BYPASS_EN
  always_comb begin
    if (load && (w_pc == r_pc)) begin
      btb_hit    = 1'b1;
      target_out = target_in;
    end else begin
      btb_hit    = rd_hit;
      target_out = rd_target;
    end
  end
`else
  assign btb_hit    = rd_hit;
  assign target_out = rd_target;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus queues expectations, monitor compares.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] r_pc;
  logic [31:0] target_out;
  logic        btb_hit;
  logic [31:0] w_pc;
  logic        load;
  logic [31:0] target_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;   // 0 lookup, 1 plru state
    string       name;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] tgt;
    int          set;
    logic [2:0]  plru;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  branch_target_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .r_pc       (r_pc),
    .target_out (target_out),
    .btb_hit    (btb_hit),
    .w_pc       (w_pc),
    .load       (load),
    .target_in  (target_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one queued expectation is checked mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (e.kind == 0) begin
        if (r_pc !== e.pc || btb_hit !== e.hit || target_out !== e.tgt) begin
          errors++;
          $display("FAIL %s: got pc=%h hit=%b tgt=%h, want pc=%h hit=%b tgt=%h",
                   e.name, r_pc, btb_hit, target_out, e.pc, e.hit, e.tgt);
        end
      end else begin
        if (dut.u_plru.plru_q[e.set] !== e.plru) begin
          errors++;
          $display("FAIL %s: got plru=%b, want plru=%b",
                   e.name, dut.u_plru.plru_q[e.set], e.plru);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_look(input string n, input logic [31:0] pc, input logic h,
                           input logic [31:0] t);
    exp_t x;
    x.kind = 0; x.name = n; x.pc = pc; x.hit = h; x.tgt = t; x.set = 0; x.plru = 3'b000;
    r_pc = pc;
    exp_q.push_back(x);
  endtask

  task automatic look(input string n, input logic [31:0] pc, input logic h,
                      input logic [31:0] t);
    push_look(n, pc, h, t);
    cyc();
  endtask

  task automatic chk_plru(input string n, input int s, input logic [2:0] p);
    exp_t x;
    x.kind = 1; x.name = n; x.pc = 32'h0; x.hit = 1'b0; x.tgt = 32'h0; x.set = s; x.plru = p;
    exp_q.push_back(x);
    cyc();
  endtask

  task automatic write(input logic [31:0] pc, input logic [31:0] t);
    load = 1'b1; w_pc = pc; target_in = t;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; w_pc = '0; target_in = '0; r_pc = 32'h1D;
    cyc();
    look("in_reset", 32'h0000001D, 1'b0, 32'h0);
    rst = 1'b0;
    look("after_reset", 32'h0000001D, 1'b0, 32'h0);

    write(32'h00000010, 32'h600D600D);
    chk_plru("plru_set4", 4, 3'b101);
    look("hit_0x10", 32'h00000010, 1'b1, 32'h600D600D);
    look("miss_0x1d", 32'h0000001D, 1'b0, 32'h0);

    // Simultaneous write and read of the same PC.
    load = 1'b1; w_pc = 32'h2D; target_in = 32'hDEADBEEF;
`ifdef BTB_BYPASS_EN
    push_look("same_cycle", 32'h0000002D, 1'b1, 32'hDEADBEEF);
`else
    push_look("same_cycle", 32'h0000002D, 1'b0, 32'h0);
`endif
    cyc();
    load = 1'b0;
    look("after_edge_0x2d", 32'h0000002D, 1'b1, 32'hDEADBEEF);
    chk_plru("plru_set3_a", 3, 3'b101);

    write(32'h1000002D, 32'hFEEBFEEB);
    chk_plru("plru_set3_b", 3, 3'b011);
    look("alloc_way0", 32'h1000002D, 1'b1, 32'hFEEBFEEB);
    look("keep_0x2d", 32'h0000002D, 1'b1, 32'hDEADBEEF);

    write(32'h1000002D, 32'h00BADBAD);
    look("update_in_place", 32'h1000002D, 1'b1, 32'h00BADBAD);
    look("keep_0x2d_2", 32'h0000002D, 1'b1, 32'hDEADBEEF);
    chk_plru("plru_set3_c", 3, 3'b011);

    // Fill: way2, way1, then way3 (holding 0x2D) is evicted.
    write(32'h2000002D, 32'hAAAA0001);
    chk_plru("plru_set3_d", 3, 3'b110);
    write(32'h3000002D, 32'hBBBB0002);
    chk_plru("plru_set3_e", 3, 3'b000);
    write(32'h4000002D, 32'hCCCC0003);
    chk_plru("plru_set3_f", 3, 3'b101);
    look("evicted_0x2d", 32'h0000002D, 1'b0, 32'h0);
    look("fill_t1", 32'h1000002D, 1'b1, 32'h00BADBAD);
    look("fill_t2", 32'h2000002D, 1'b1, 32'hAAAA0001);
    look("fill_t3", 32'h3000002D, 1'b1, 32'hBBBB0002);
    look("fill_t4", 32'h4000002D, 1'b1, 32'hCCCC0003);
    look("other_set", 32'h00000010, 1'b1, 32'h600D600D);

    // Mid-sequence reset with a pending write that must be ignored.
    load = 1'b1; w_pc = 32'h50; target_in = 32'h12345678;
    rst = 1'b1;
    look("rst_miss_t4", 32'h4000002D, 1'b0, 32'h0);
    look("rst_miss_0x10", 32'h00000010, 1'b0, 32'h0);
    rst = 1'b0; load = 1'b0;
    look("rst_no_write", 32'h00000050, 1'b0, 32'h0);
    chk_plru("plru_rst", 3, 3'b000);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
